// File: rtl/kernel_bank_sel.sv
// Selects a K_DIM x K_DIM signed convolution kernel from a debounced mode switch or a
// runtime-loaded custom bank; every kernel change is applied only on frame_start_i.
module kernel_bank_sel #(
    parameter int K_DIM         = 3,
    parameter int COEF_W        = 9,
    parameter int MODE_W        = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [MODE_W-1:0]                        switch_i,
    input  logic                                     frame_start_i,
    input  logic                                     load_v_i,
    input  logic [COEF_W-1:0]                        load_data_i,
    input  logic                                     load_last_i,
    output logic                                     load_ready_o,
    output logic                                     load_err_o,
    output logic [K_DIM-1:0][K_DIM-1:0][COEF_W-1:0] filter_o,
    output logic [3:0]                               norm_shift_o,
    output logic [MODE_W-1:0]                        mode_o,
    output logic                                     v_o,
    output logic                                     pending_o,
    output logic [1:0]                               state_o
);
    // Load handshake: a coefficient transfers on every cycle where load_v_i and
    // load_ready_o are both high; load_v_i may be held regardless of ready.

    localparam int N     = K_DIM * K_DIM;
    localparam int C     = K_DIM / 2;
    localparam int CNT_W = $clog2(N);
    localparam int DB_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  CTR_IDX  = CNT_W'(C * K_DIM + C);
    localparam logic [MODE_W-1:0] MODE_CUST = MODE_W'(5);
    localparam logic [MODE_W-1:0] MODE_GAUS = MODE_W'(4);

    // Flat element index r*K_DIM+c matches filter_o[r][c]; raster index i lands at N-1-i.
    typedef logic [N-1:0][COEF_W-1:0] bank_t;
    typedef enum logic [1:0] {S_INIT, S_ACTIVE, S_PENDING} state_t;

    function automatic bank_t identity();
        bank_t b;
        b = '0;
        b[CTR_IDX] = COEF_W'(1);
        return b;
    endfunction

    function automatic bank_t preset(input logic [MODE_W-1:0] m);
        bank_t b;
        int t [3][3];
        logic [CNT_W-1:0] idx;
        b = '0;
        case (m)
            MODE_W'(1): t = '{'{-1, -1, -1}, '{-1, 8, -1}, '{-1, -1, -1}};
            MODE_W'(2): t = '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}};
            MODE_W'(3): t = '{'{-2, -1, 0}, '{-1, 1, 1}, '{0, 1, 2}};
            MODE_W'(4): t = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
            default:    t = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
        endcase
        for (int pr = 0; pr < 3; pr++) begin
            for (int pc = 0; pc < 3; pc++) begin
                idx = CNT_W'((C + 1 - pr) * K_DIM + (C + 1 - pc));
                b[idx] = COEF_W'(t[pr][pc]);
            end
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][MODE_W-1:0] sync_q;
    logic [MODE_W-1:0] sync_val, last_val, req_mode;
    logic [DB_W-1:0]   db_cnt;
    logic              accept, commit, cust_commit, update, beat, last_slot;
    logic              cust_pending;
    logic [CNT_W-1:0]  cnt;
    logic [MODE_W-1:0] sel_mode;
    bank_t             shadow, bank, bank_src, nxt_filter, filt_q;
    state_t            state;

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign filter_o = filt_q;
    assign state_o  = state;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q   <= '0;
            last_val <= '0;
            db_cnt   <= '0;
        end else begin
            sync_q <= (SYNC_STAGES * MODE_W)'({sync_q, switch_i});
            if (sync_val != last_val) begin
                last_val <= sync_val;
                db_cnt   <= '0;
            end else if (db_cnt != DB_W'(STABLE_CYCLES)) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // One-shot: fires only on the cycle the counter reaches the threshold.
    assign accept = (sync_val == last_val) && (db_cnt == DB_W'(STABLE_CYCLES - 1)) &&
                    ((sync_val != mode_o) || !v_o);
    assign commit      = (state == S_PENDING) && frame_start_i && !accept;
    assign cust_commit = cust_pending && frame_start_i;
    assign sel_mode    = commit ? req_mode : mode_o;
    assign bank_src    = cust_commit ? shadow : bank;
    assign update      = commit || (cust_commit && (sel_mode == MODE_CUST));

    always_comb begin
        nxt_filter = preset(sel_mode);
        if (sel_mode == MODE_CUST) nxt_filter = bank_src;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= S_INIT;
            req_mode     <= '0;
            mode_o       <= '0;
            v_o          <= 1'b0;
            pending_o    <= 1'b0;
            filt_q       <= identity();
            norm_shift_o <= 4'd0;
        end else begin
            if (update) begin
                filt_q       <= nxt_filter;
                norm_shift_o <= (sel_mode == MODE_GAUS) ? 4'd4 : 4'd0;
            end
            case (state)
                S_INIT, S_ACTIVE: begin
                    if (accept) begin
                        req_mode  <= sync_val;
                        pending_o <= 1'b1;
                        state     <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (accept) begin
                        req_mode <= sync_val;
                    end else if (frame_start_i) begin
                        mode_o    <= req_mode;
                        v_o       <= 1'b1;
                        pending_o <= 1'b0;
                        state     <= S_ACTIVE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign beat      = load_v_i && load_ready_o;
    assign last_slot = (cnt == LAST_IDX);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt          <= '0;
            shadow       <= identity();
            bank         <= identity();
            cust_pending <= 1'b0;
            load_ready_o <= 1'b0;
            load_err_o   <= 1'b0;
        end else begin
            load_err_o <= 1'b0;
            if (cust_commit) begin
                bank         <= shadow;
                cust_pending <= 1'b0;
                load_ready_o <= 1'b1;
            end else if (!cust_pending) begin
                load_ready_o <= 1'b1;
            end
            if (beat) begin
                if (load_last_i && last_slot) begin
                    shadow[LAST_IDX - cnt] <= load_data_i;
                    cust_pending <= 1'b1;
                    load_ready_o <= 1'b0;
                    cnt          <= '0;
                end else if (load_last_i || last_slot) begin
                    // Malformed load: drop the beat and everything gathered so far.
                    load_err_o <= 1'b1;
                    shadow     <= identity();
                    cnt        <= '0;
                end else begin
                    shadow[LAST_IDX - cnt] <= load_data_i;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_kernel_bank_sel.sv
// Directed-plus-random bench for kernel_bank_sel against a raster-order kernel model.
module tb_kernel_bank_sel;
    localparam int K = 3;
    localparam int W = 9;
    localparam int MW = 3;
    localparam int N = K * K;
    localparam int FW = N * W;

    logic clk = 1'b0;
    logic reset_i;
    logic [MW-1:0] switch_i;
    logic frame_start, load_v, load_last;
    logic [W-1:0] load_data;
    logic load_ready, load_err, v_o, pending_o;
    logic [K-1:0][K-1:0][W-1:0] filter_o;
    logic [3:0] norm_shift;
    logic [MW-1:0] mode_o;
    logic [1:0] state_o;

    int total = 0;
    int bad = 0;
    int m_mode = 0;
    int m_valid = 0;
    int m_bank [N];
    int vals [N];

    kernel_bank_sel #(.K_DIM(K), .COEF_W(W), .MODE_W(MW), .SYNC_STAGES(2), .STABLE_CYCLES(16)) dut (
        .clk_i(clk), .reset_i(reset_i), .switch_i(switch_i), .frame_start_i(frame_start),
        .load_v_i(load_v), .load_data_i(load_data), .load_last_i(load_last),
        .load_ready_o(load_ready), .load_err_o(load_err), .filter_o(filter_o),
        .norm_shift_o(norm_shift), .mode_o(mode_o), .v_o(v_o), .pending_o(pending_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Kernel built from the preset tables in raster order, centred in a zero K x K frame.
    function automatic logic [FW-1:0] ref_kernel(input int mode, input int bank [N]);
        int v [N];
        int t [9];
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) v[i] = 0;
        case (mode)
            1: t = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
            2: t = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
            3: t = '{-2, -1, 0, -1, 1, 1, 0, 1, 2};
            4: t = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
            default: t = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        endcase
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(K / 2 - 1 + r) * K + (K / 2 - 1 + c)] = t[r * 3 + c];
        if (mode == 5) v = bank;
        f = '0;
        for (int i = 0; i < N; i++) f[(N - 1 - i) * W +: W] = W'(v[i]);
        return f;
    endfunction

    task automatic check_state(input string tag, input int exp_pending);
        chk({tag, "_filter"}, 128'(filter_o), 128'(ref_kernel(m_mode, m_bank)));
        chk({tag, "_mode"}, 128'(mode_o), 128'(m_mode));
        chk({tag, "_shift"}, 128'(norm_shift), (m_mode == 4) ? 128'd4 : 128'd0);
        chk({tag, "_valid"}, 128'(v_o), 128'(m_valid));
        chk({tag, "_pending"}, 128'(pending_o), 128'(exp_pending));
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_switch_settle(input int m);
        switch_i = MW'(m);
        tick(25);
    endtask

    // Drives `count` beats from vals[], raising load_last on beat index last_at.
    task automatic load_seq(input string tag, input int count, input int last_at);
        for (int i = 0; i < count; i++) begin
            chk({tag, "_ready_beat"}, 128'(load_ready), 128'd1);
            load_v = 1'b1;
            load_data = W'(vals[i]);
            load_last = (i == last_at);
            tick();
            load_v = 1'b0;
            load_last = 1'b0;
        end
    endtask

    task automatic rand_vals();
        for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, (1 << W) - 1));
    endtask

    initial begin
        int rm;
        int picks [5];
        picks = '{0, 1, 3, 6, 7};
        reset_i = 1'b0;
        switch_i = MW'(2);
        frame_start = 1'b0;
        load_v = 1'b0;
        load_last = 1'b0;
        load_data = '0;
        for (int i = 0; i < N; i++) m_bank[i] = (i == N / 2) ? 1 : 0;

        // Reset values, then ready on the first clock after release.
        tick(3);
        check_state("rst", 0);
        chk("rst_ready", 128'(load_ready), 128'd0);
        chk("rst_err", 128'(load_err), 128'd0);
        reset_i = 1'b1;
        tick();
        chk("rel_ready", 128'(load_ready), 128'd1);

        // First accept from INIT, then commit sharpen.
        tick(25);
        check_state("init_pend", 1);
        frame_pulse();
        m_mode = 2;
        m_valid = 1;
        check_state("sharpen", 0);

        // Bouncing switch never settles long enough to be accepted.
        for (int i = 0; i < 8; i++) begin
            switch_i = (i % 2 == 0) ? MW'(1) : MW'(2);
            tick(5);
        end
        tick(20);
        check_state("bounce", 0);
        frame_pulse();
        check_state("bounce_fs", 0);

        // Random preset (including out-of-range modes reported raw, kernel identity).
        rm = picks[$urandom_range(0, 4)];
        set_switch_settle(rm);
        check_state("rand_pend", 1);
        frame_pulse();
        m_mode = rm;
        check_state("rand_mode", 0);

        // Gaussian waits for the frame boundary however long it takes.
        set_switch_settle(4);
        tick(100);
        check_state("gaus_hold", 1);
        frame_pulse();
        m_mode = 4;
        check_state("gaus", 0);

        // Custom load 1..9 together with a pending switch to mode 5.
        set_switch_settle(5);
        for (int i = 0; i < N; i++) vals[i] = i + 1;
        load_seq("ld1", N, N - 1);
        chk("ld1_ready_low", 128'(load_ready), 128'd0);
        chk("ld1_err", 128'(load_err), 128'd0);
        tick(3);
        chk("ld1_ready_hold", 128'(load_ready), 128'd0);
        check_state("ld1_precommit", 1);
        frame_pulse();
        m_mode = 5;
        m_bank = vals;
        check_state("ld1_commit", 0);
        chk("ld1_ready_back", 128'(load_ready), 128'd1);

        // Early last and overrun both pulse load_err_o and leave the bank intact.
        rand_vals();
        load_seq("short", 4, 3);
        chk("short_err", 128'(load_err), 128'd1);
        tick();
        chk("short_err_pulse", 128'(load_err), 128'd0);
        load_seq("over", N, -1);
        chk("over_err", 128'(load_err), 128'd1);
        tick();
        chk("over_err_pulse", 128'(load_err), 128'd0);
        frame_pulse();
        check_state("err_bank", 0);

        // Random load while mode 5 is already active refreshes the kernel at the boundary.
        rand_vals();
        load_seq("ld2", N, N - 1);
        tick(2);
        check_state("ld2_hold", 0);
        frame_pulse();
        m_bank = vals;
        check_state("ld2_commit", 0);

        // A load under another mode still updates the bank.
        set_switch_settle(1);
        frame_pulse();
        m_mode = 1;
        check_state("hp", 0);
        rand_vals();
        load_seq("ld3", N, N - 1);
        frame_pulse();
        m_bank = vals;
        check_state("ld3_hp", 0);
        chk("ld3_ready", 128'(load_ready), 128'd1);
        set_switch_settle(5);
        frame_pulse();
        m_mode = 5;
        check_state("ld3_cust", 0);

        // Asynchronous reset mid-load with a change pending.
        set_switch_settle(3);
        rand_vals();
        load_seq("ld4", 5, -1);
        #2;
        reset_i = 1'b0;
        #1;
        m_mode = 0;
        m_valid = 0;
        for (int i = 0; i < N; i++) m_bank[i] = (i == N / 2) ? 1 : 0;
        check_state("mid_rst", 0);
        chk("mid_rst_ready", 128'(load_ready), 128'd0);
        tick(2);
        reset_i = 1'b1;
        tick();
        chk("rel2_ready", 128'(load_ready), 128'd1);
        rand_vals();
        load_seq("ld5", N, N - 1);
        chk("ld5_err", 128'(load_err), 128'd0);
        chk("ld5_ready_low", 128'(load_ready), 128'd0);
        tick(25);
        check_state("ld5_pend", 1);
        frame_pulse();
        m_mode = 3;
        m_valid = 1;
        m_bank = vals;
        check_state("emboss", 0);
        chk("ld5_ready_back", 128'(load_ready), 128'd1);
        set_switch_settle(5);
        frame_pulse();
        m_mode = 5;
        check_state("ld5_cust", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
